cv32e40p_if_id_queue: RTL and testbench
=======================================

# cv32e40p_if_id_queue

Parametrised IF/ID decoupling queue that replaces the single-entry IF/ID pipeline register with a DEPTH-entry circular buffer. It sits between the aligner/compressed-decoder output of the fetch stage and the ID stage. Fetch can run ahead while ID is stalled, and the whole queue is flushed atomically on a PC redirect. Each entry carries the decompressed instruction, its PC and the per-instruction flags ID consumes.

## Interface
- DEPTH, 2, number of entries; legal range 1..8; non-power-of-two values allowed.
- INSTR_WIDTH, 32, width of the instruction field.
- PC_WIDTH, 32, width of the PC field.
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- push_valid_i  in  1  IF offers an aligned, decompressed instruction
- push_ready_o  out  1  queue accepts the offered instruction
- halt_if_i  in  1  blocks push (push_ready_o forced 0)
- instr_i  in  INSTR_WIDTH  decompressed instruction
- pc_i  in  PC_WIDTH  PC of instr_i
- is_compressed_i  in  1  original encoding was RVC
- illegal_c_insn_i  in  1  compressed decoder flagged illegal
- fetch_failed_i  in  1  fetch error for this instruction
- flush_i  in  1  PC redirect (pc_set) or clear_instr_valid; empties the queue
- instr_valid_id_o  out  1  head entry valid
- id_ready_i  in  1  ID consumes the head this cycle
- instr_rdata_id_o  out  INSTR_WIDTH  head instruction
- pc_id_o  out  PC_WIDTH  head PC
- is_compressed_id_o  out  1  head RVC flag
- illegal_c_insn_id_o  out  1  head illegal-RVC flag
- is_fetch_failed_o  out  1  head fetch-failed flag
- occupancy_o  out  $clog2(DEPTH+1)  current entry count
- perf_full_o  out  1  high while push_valid_i is stalled by a full queue

## Operation
- State: wr_ptr and rd_ptr, each in 0..DEPTH-1; count in 0..DEPTH; storage array of DEPTH entries.
- push = push_valid_i & push_ready_o. pop = instr_valid_id_o & id_ready_i.
- push_ready_o = ~halt_if_i & ~flush_i & (count < DEPTH). There is no same-cycle pass-through when full, so no combinational id_ready_i→push_ready_o path exists (default build).
- Pointer increment wraps to 0 after DEPTH-1; it is never a power-of-two mask.
- count update: count + push − pop. Simultaneous push and pop leave count unchanged, the write lands at wr_ptr, and the head advances.
- instr_valid_id_o = (count != 0). Head fields are read from storage[rd_ptr].
- flush_i has priority over push and pop: next cycle count=0, wr_ptr=rd_ptr=0. A push or pop offered in the flush cycle is discarded.
- After flush, stale head data may remain on the data outputs. instr_valid_id_o is 0, so ID must ignore those outputs.
- perf_full_o = push_valid_i & ~halt_if_i & ~flush_i & (count == DEPTH).
- DEPTH=1 behaves like the legacy single IF/ID register, except that a refill needs the entry popped first.

## Timing
- Reset: count=0, pointers=0, storage cleared to 0, instr_valid_id_o=0, all head outputs 0, occupancy_o=0, push_ready_o=~halt_if_i, perf_full_o=0.
- Push-to-valid latency is 1 cycle. A push at edge N gives instr_valid_id_o=1 after edge N.
- Pop-to-next-head latency is 0 cycles. The next entry is presented immediately after the popping edge.
- The full→not-full transition is visible on push_ready_o in the cycle after the pop.
- Reset asserted mid-operation discards all entries asynchronously.

## Configuration
- CV32E40P_IFQ_BYPASS_EN defined: when count==0 and push_valid_i is high, the input fields drive the head outputs combinationally and instr_valid_id_o = push_valid_i & ~halt_if_i & ~flush_i.
  - If id_ready_i is also high, the instruction is consumed without being written.
  - push_ready_o additionally goes high when count==DEPTH & id_ready_i, adding a combinational ready path.
  - Zero-cycle latency.
- CV32E40P_IFQ_BYPASS_EN undefined: behaviour exactly as in Operation, with 1-cycle latency and fully registered outputs.

## Test plan
- Reset, DEPTH=2 → all outputs 0, push_ready_o=1. Push pc=0x80, instr=0x00000013 → next cycle instr_valid_id_o=1, pc_id_o=0x80, occupancy_o=1.
- DEPTH=3, id_ready_i=0, push 3 instructions (pc 0x100/0x104/0x108) with push_valid_i held for a 4th (pc 0x10C):
  - push_ready_o=0 and perf_full_o=1 after the third push.
  - Then id_ready_i=1 pops in order 0x100, 0x104, 0x108, 0x10C with no loss.
- DEPTH=3, continuous push and pop for 10 instructions → pointers wrap 2→0, occupancy_o stays constant, and PCs emerge strictly in order.
- Queue holding 2 entries, flush_i=1 with simultaneous push (pc 0x200) and id_ready_i=1 → next cycle instr_valid_id_o=0, occupancy_o=0, and pc 0x200 never appears.
- halt_if_i=1 with push_valid_i=1 → push_ready_o=0, perf_full_o=0, occupancy_o unchanged. Head with is_compressed_i=1, illegal_c_insn_i=1, fetch_failed_i=1 → all three flags appear unchanged on pop.
- With CV32E40P_IFQ_BYPASS_EN: empty queue, push pc=0x300 with id_ready_i=1 → instr_valid_id_o=1 and pc_id_o=0x300 in the same cycle, occupancy_o remains 0.

Source files
------------

// File: rtl/cv32e40p_if_id_queue_if.sv
// cv32e40p_if_id_queue_if
// Bundles the IF-side push handshake, the ID-side head/consume handshake and
// the status outputs of the IF/ID decoupling queue.
//   slave  : the queue's view (takes push/flush/halt/id_ready, drives head)
//   master : the surrounding pipeline's view (IF pushes, ID consumes)
// Parameters: INSTR_WIDTH, PC_WIDTH, OCC_WIDTH (= $clog2(DEPTH+1) of the queue).
interface cv32e40p_if_id_queue_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 32,
  parameter int OCC_WIDTH   = 2
);
  // IF side
  logic                   push_valid_i;
  logic                   push_ready_o;
  logic                   halt_if_i;
  logic [INSTR_WIDTH-1:0] instr_i;
  logic [PC_WIDTH-1:0]    pc_i;
  logic                   is_compressed_i;
  logic                   illegal_c_insn_i;
  logic                   fetch_failed_i;
  logic                   flush_i;
  // ID side
  logic                   instr_valid_id_o;
  logic                   id_ready_i;
  logic [INSTR_WIDTH-1:0] instr_rdata_id_o;
  logic [PC_WIDTH-1:0]    pc_id_o;
  logic                   is_compressed_id_o;
  logic                   illegal_c_insn_id_o;
  logic                   is_fetch_failed_o;
  // status
  logic [OCC_WIDTH-1:0]   occupancy_o;
  logic                   perf_full_o;

  modport slave (
    input  push_valid_i, halt_if_i, instr_i, pc_i, is_compressed_i,
           illegal_c_insn_i, fetch_failed_i, flush_i, id_ready_i,
    output push_ready_o, instr_valid_id_o, instr_rdata_id_o, pc_id_o,
           is_compressed_id_o, illegal_c_insn_id_o, is_fetch_failed_o,
           occupancy_o, perf_full_o
  );

  modport master (
    output push_valid_i, halt_if_i, instr_i, pc_i, is_compressed_i,
           illegal_c_insn_i, fetch_failed_i, flush_i, id_ready_i,
    input  push_ready_o, instr_valid_id_o, instr_rdata_id_o, pc_id_o,
           is_compressed_id_o, illegal_c_insn_id_o, is_fetch_failed_o,
           occupancy_o, perf_full_o
  );
endinterface

// File: rtl/cv32e40p_if_id_queue.sv
// cv32e40p_if_id_queue
// DEPTH-entry circular buffer between the fetch aligner/compressed decoder and
// the ID stage. Fetch may run ahead while ID stalls; flush_i empties the queue
// atomically on a PC redirect. Each entry holds {fetch_failed, illegal_c,
// is_compressed, pc, instr}.
// Ports:
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : cv32e40p_if_id_queue_if.slave (push handshake, head outputs,
//                id_ready_i consume, flush/halt, occupancy_o, perf_full_o)
// Parameters: DEPTH (1..8, any value), INSTR_WIDTH, PC_WIDTH. The interface
// instance must use OCC_WIDTH = $clog2(DEPTH+1).
// Optional feature: define CV32E40P_IFQ_BYPASS_EN to let an instruction
// offered to an empty queue appear on the head outputs in the same cycle
// (and be consumed without being written if ID is ready). Without it all
// head outputs come straight from registers with one cycle of latency.
module cv32e40p_if_id_queue #(
  parameter int DEPTH       = 2,
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  cv32e40p_if_id_queue_if.slave  bus
);

  localparam int OCC_W   = $clog2(DEPTH + 1);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = INSTR_WIDTH + PC_WIDTH + 3;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

  logic [DEPTH-1:0][ENTRY_W-1:0] storage;
  logic [PTR_W-1:0]              wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]              rd_ptr_reg, rd_ptr_next;
  logic [OCC_W-1:0]              count_reg, count_next;

  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               empty, full;
  logic               push_ready, head_valid;
  logic               push, pop;
  logic               bypass_consume;
  logic               do_write, do_read;

  assign in_entry = {bus.fetch_failed_i, bus.illegal_c_insn_i, bus.is_compressed_i,
                     bus.pc_i, bus.instr_i};
  assign empty    = (count_reg == '0);
  assign full     = (count_reg == FULL_CNT);

`ifdef CV32E40P_IFQ_BYPASS_EN
  logic bypass;
  // Empty queue with an offer: present the incoming instruction directly.
  assign bypass         = empty & bus.push_valid_i;
  // When full, a consuming ID frees the slot being written this same cycle.
  assign push_ready     = ~bus.halt_if_i & ~bus.flush_i & (~full | bus.id_ready_i);
  assign head_valid     = bypass ? (bus.push_valid_i & ~bus.halt_if_i & ~bus.flush_i)
                                 : ~empty;
  assign head_entry     = bypass ? in_entry : storage[rd_ptr_reg];
  // Instruction taken straight from the input never touches storage.
  assign bypass_consume = bypass & head_valid & bus.id_ready_i;
`else
  assign push_ready     = ~bus.halt_if_i & ~bus.flush_i & ~full;
  assign head_valid     = ~empty;
  assign head_entry     = storage[rd_ptr_reg];
  assign bypass_consume = 1'b0;
`endif

  assign push     = bus.push_valid_i & push_ready;
  assign pop      = head_valid & bus.id_ready_i;
  assign do_write = push & ~bypass_consume;
  assign do_read  = pop & ~bypass_consume;

  // Pointer/count next state; flush wins over any push or pop this cycle.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (bus.flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
      if (do_write) begin
        wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
      end
      if (do_read) begin
        rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
      end
      case ({do_write, do_read})
        2'b10:   count_next = count_reg + OCC_W'(1);
        2'b01:   count_next = count_reg - OCC_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // One register per entry; cleared on reset so the head reads 0 after reset.
  // do_write is already blocked by flush through push_ready.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [ENTRY_W-1:0] entry_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (do_write && (wr_ptr_reg == PTR_W'(gi))) begin
          entry_reg <= in_entry;
        end
      end
      assign storage[gi] = entry_reg;
    end
  endgenerate

  assign bus.push_ready_o        = push_ready;
  assign bus.instr_valid_id_o    = head_valid;
  assign bus.instr_rdata_id_o    = head_entry[INSTR_WIDTH-1:0];
  assign bus.pc_id_o             = head_entry[INSTR_WIDTH +: PC_WIDTH];
  assign bus.is_compressed_id_o  = head_entry[INSTR_WIDTH+PC_WIDTH];
  assign bus.illegal_c_insn_id_o = head_entry[INSTR_WIDTH+PC_WIDTH+1];
  assign bus.is_fetch_failed_o   = head_entry[INSTR_WIDTH+PC_WIDTH+2];
  assign bus.occupancy_o         = count_reg;
  assign bus.perf_full_o         = bus.push_valid_i & ~bus.halt_if_i & ~bus.flush_i & full;

endmodule

// File: tb/tb_cv32e40p_if_id_queue.sv
// tb_cv32e40p_if_id_queue
// Directed bench for the IF/ID queue: a DEPTH=2 instance for reset/first-push
// and full handshake, a DEPTH=3 instance driven from a vector table
// (backpressure, wrap, flush, halt, flags), then an asynchronous mid-run reset.
// Inputs change on the falling edge; combinational outputs are sampled 1 time
// unit later, registered outputs 1 time unit after the rising edge.
module tb_cv32e40p_if_id_queue;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cv32e40p_if_id_queue_if #(.INSTR_WIDTH(32), .PC_WIDTH(32), .OCC_WIDTH(2)) bus2 ();
  cv32e40p_if_id_queue_if #(.INSTR_WIDTH(32), .PC_WIDTH(32), .OCC_WIDTH(2)) bus3 ();

  cv32e40p_if_id_queue #(.DEPTH(2), .INSTR_WIDTH(32), .PC_WIDTH(32)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );
  cv32e40p_if_id_queue #(.DEPTH(3), .INSTR_WIDTH(32), .PC_WIDTH(32)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  typedef struct {
    logic        pv, halt, flush, rdy;
    logic [31:0] pc;
    logic [2:0]  fl;     // {fetch_failed, illegal_c, is_compressed}
    logic        e_pr, e_pf, e_v;
    logic [31:0] e_pc;
    logic [2:0]  e_fl;
    logic [1:0]  e_occ;  // occupancy after the edge
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic add(input logic pv, input logic halt, input logic flush, input logic rdy,
                     input logic [31:0] pc, input logic [2:0] fl,
                     input logic e_pr, input logic e_pf, input logic e_v,
                     input logic [31:0] e_pc, input logic [2:0] e_fl, input logic [1:0] e_occ);
    vec_t v;
    v.pv = pv; v.halt = halt; v.flush = flush; v.rdy = rdy; v.pc = pc; v.fl = fl;
    v.e_pr = e_pr; v.e_pf = e_pf; v.e_v = e_v; v.e_pc = e_pc; v.e_fl = e_fl; v.e_occ = e_occ;
    vecs.push_back(v);
  endtask

  task automatic idle2();
    bus2.push_valid_i = 0; bus2.halt_if_i = 0; bus2.flush_i = 0; bus2.id_ready_i = 0;
    bus2.instr_i = 0; bus2.pc_i = 0; bus2.is_compressed_i = 0;
    bus2.illegal_c_insn_i = 0; bus2.fetch_failed_i = 0;
  endtask

  task automatic drive3(input logic pv, input logic halt, input logic flush, input logic rdy,
                        input logic [31:0] pc, input logic [2:0] fl);
    bus3.push_valid_i = pv; bus3.halt_if_i = halt; bus3.flush_i = flush;
    bus3.id_ready_i = rdy; bus3.pc_i = pc; bus3.instr_i = instr_of(pc);
    bus3.is_compressed_i = fl[0]; bus3.illegal_c_insn_i = fl[1]; bus3.fetch_failed_i = fl[2];
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle2();
    drive3(0, 0, 0, 0, 32'h0, 3'b000);

    // ---------------- vector table (DEPTH=3) ----------------
    // backpressure: 3 pushes fill, 4th held, then in-order drain
    add(1,0,0,0, 32'h100,0, 1,0,0, 32'h0,  0, 1);
    add(1,0,0,0, 32'h104,0, 1,0,1, 32'h100,0, 2);
    add(1,0,0,0, 32'h108,0, 1,0,1, 32'h100,0, 3);
    add(1,0,0,0, 32'h10C,0, 0,1,1, 32'h100,0, 3);
    add(1,0,0,1, 32'h10C,0, 0,1,1, 32'h100,0, 2);
    add(1,0,0,1, 32'h10C,0, 1,0,1, 32'h104,0, 2);
    add(0,0,0,1, 32'h0,  0, 1,0,1, 32'h108,0, 1);
    add(0,0,0,1, 32'h0,  0, 1,0,1, 32'h10C,0, 0);
    add(0,0,0,1, 32'h0,  0, 1,0,0, 32'h0,  0, 0);
    // continuous push+pop: occupancy stays 1, pointers wrap repeatedly
    for (int k = 0; k < 10; k++) begin
      add(1,0,0,(k > 0), 32'h400 + 32'(4*k), 0,
          1,0,(k > 0), 32'h400 + 32'(4*(k-1)), 0, 1);
    end
    add(0,0,0,1, 32'h0,0, 1,0,1, 32'h424,0, 0);
    // flush with simultaneous push (0x200) and pop discards everything
    add(1,0,0,0, 32'h500,0, 1,0,0, 32'h0,  0, 1);
    add(1,0,0,0, 32'h504,0, 1,0,1, 32'h500,0, 2);
    add(1,0,1,1, 32'h200,0, 0,0,1, 32'h500,0, 0);
    add(0,0,0,0, 32'h0,  0, 1,0,0, 32'h0,  0, 0);
    add(1,0,0,0, 32'h600,0, 1,0,0, 32'h0,  0, 1);
    add(0,0,0,1, 32'h0,  0, 1,0,1, 32'h600,0, 0);
    // halt blocks push; flags travel unchanged; halt while full is not perf_full
    add(1,0,0,0, 32'h700,0, 1,0,0, 32'h0,  0, 1);
    add(1,1,0,0, 32'h704,0, 0,0,1, 32'h700,0, 1);
    add(1,0,0,0, 32'h708,7, 1,0,1, 32'h700,0, 2);
    add(1,0,0,0, 32'h70C,0, 1,0,1, 32'h700,0, 3);
    add(1,1,0,0, 32'h710,0, 0,0,1, 32'h700,0, 3);
    add(0,0,0,1, 32'h0,  0, 0,0,1, 32'h700,0, 2);
    add(0,0,0,1, 32'h0,  0, 1,0,1, 32'h708,7, 1);
    add(0,0,0,1, 32'h0,  0, 1,0,1, 32'h70C,0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- DEPTH=2: reset state and first push ----------------
    #1;
    check("d2 reset valid",      bus2.instr_valid_id_o, 0);
    check("d2 reset pc",         bus2.pc_id_o, 0);
    check("d2 reset instr",      bus2.instr_rdata_id_o, 0);
    check("d2 reset flags",      {bus2.is_fetch_failed_o, bus2.illegal_c_insn_id_o,
                                  bus2.is_compressed_id_o}, 0);
    check("d2 reset occupancy",  bus2.occupancy_o, 0);
    check("d2 reset push_ready", bus2.push_ready_o, 1);
    check("d2 reset perf_full",  bus2.perf_full_o, 0);

    @(negedge clk);
    bus2.push_valid_i = 1; bus2.pc_i = 32'h80; bus2.instr_i = 32'h0000_0013;
    @(posedge clk); #1;
    check("d2 push valid",     bus2.instr_valid_id_o, 1);
    check("d2 push pc",        bus2.pc_id_o, 32'h80);
    check("d2 push instr",     bus2.instr_rdata_id_o, 32'h13);
    check("d2 push occupancy", bus2.occupancy_o, 1);
    @(negedge clk);
    bus2.pc_i = 32'h84; bus2.instr_i = 32'h0000_0093;
    @(posedge clk); #1;
    check("d2 fill occupancy", bus2.occupancy_o, 2);
    @(negedge clk);
    bus2.pc_i = 32'h88; bus2.id_ready_i = 1;
    #1;
    check("d2 full push_ready", bus2.push_ready_o, 0);
    check("d2 full perf_full",  bus2.perf_full_o, 1);
    check("d2 pop1 pc",         bus2.pc_id_o, 32'h80);
    @(negedge clk);
    bus2.push_valid_i = 0;
    #1;
    check("d2 after pop push_ready", bus2.push_ready_o, 1);
    check("d2 pop2 pc",              bus2.pc_id_o, 32'h84);
    check("d2 pop2 instr",           bus2.instr_rdata_id_o, 32'h93);
    @(posedge clk); #1;
    check("d2 drained valid", bus2.instr_valid_id_o, 0);
    @(negedge clk);
    idle2();

`ifdef CV32E40P_IFQ_BYPASS_EN
    // ---------------- DEPTH=3 bypass: zero-latency consume ----------------
    @(negedge clk);
    drive3(1, 0, 0, 1, 32'h300, 3'b000);
    #1;
    check("byp valid",     bus3.instr_valid_id_o, 1);
    check("byp pc",        bus3.pc_id_o, 32'h300);
    check("byp instr",     bus3.instr_rdata_id_o, instr_of(32'h300));
    check("byp occupancy", bus3.occupancy_o, 0);
    @(posedge clk); #1;
    check("byp occupancy after", bus3.occupancy_o, 0);
    @(negedge clk);
    drive3(0, 0, 0, 0, 32'h0, 3'b000);
`else
    // ---------------- DEPTH=3 vector table ----------------
    foreach (vecs[i]) begin
      @(negedge clk);
      drive3(vecs[i].pv, vecs[i].halt, vecs[i].flush, vecs[i].rdy, vecs[i].pc, vecs[i].fl);
      #1;
      check($sformatf("v%0d push_ready", i), bus3.push_ready_o, vecs[i].e_pr);
      check($sformatf("v%0d perf_full", i), bus3.perf_full_o, vecs[i].e_pf);
      check($sformatf("v%0d valid", i), bus3.instr_valid_id_o, vecs[i].e_v);
      if (vecs[i].e_v) begin
        check($sformatf("v%0d head pc", i), bus3.pc_id_o, vecs[i].e_pc);
        check($sformatf("v%0d head instr", i), bus3.instr_rdata_id_o, instr_of(vecs[i].e_pc));
        check($sformatf("v%0d head flags", i),
              {bus3.is_fetch_failed_o, bus3.illegal_c_insn_id_o, bus3.is_compressed_id_o},
              vecs[i].e_fl);
      end
      @(posedge clk); #1;
      check($sformatf("v%0d occupancy", i), bus3.occupancy_o, vecs[i].e_occ);
    end
    @(negedge clk);
    drive3(0, 0, 0, 0, 32'h0, 3'b000);
`endif

    // ---------------- asynchronous reset mid-operation ----------------
    @(negedge clk);
    drive3(1, 0, 0, 0, 32'h800, 3'b101);
    @(negedge clk);
    drive3(1, 0, 0, 0, 32'h804, 3'b000);
    @(posedge clk); #1;
    check("rst pre occupancy", bus3.occupancy_o, 2);
    @(negedge clk);
    drive3(0, 0, 0, 0, 32'h0, 3'b000);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst async occupancy", bus3.occupancy_o, 0);
    check("rst async valid",     bus3.instr_valid_id_o, 0);
    check("rst async pc",        bus3.pc_id_o, 0);
    check("rst async flags",     {bus3.is_fetch_failed_o, bus3.illegal_c_insn_id_o,
                                  bus3.is_compressed_id_o}, 0);
    check("rst push_ready",      bus3.push_ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst post occupancy", bus3.occupancy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
